// File: rtl/udp_tx_ctrl.sv
// udp_tx_ctrl: sequences one UDP payload transmit through the mac block.
// Takes a level fs/fd job, negotiates a tx slot with the mac, starts the frame,
// then streams payload bytes from the tx-side fifod on the mac's udp_txen strobes.
module udp_tx_ctrl #(
  parameter logic [31:0] TIMEOUT_CYC = 32'd65535,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [11:0] dat_tx_len,
  output logic        err,
  output logic        fifo_rxen,
  input  logic [7:0]  fifo_rxd,
  input  logic        fifo_empty,
  output logic        flag_udp_tx_req,
  input  logic        flag_udp_tx_prep,
  output logic [15:0] udp_tx_len,
  output logic        fs_udp_tx,
  input  logic        fd_udp_tx,
  input  logic        udp_txen,
  output logic [7:0]  udp_txd
);

  localparam int unsigned LEN_W = 12;
  localparam int unsigned TMO_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND,
    ST_WAIT_FD,
    ST_DONE
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               d_sel;

  logic               byte_due;
  logic [LEN_W-1:0]   cnt_inc;
  logic               tmo_hit;
  logic [TMO_W-1:0]   tmo_inc;

  // A payload byte is owed for this strobe; cnt < len keeps cnt_inc from wrapping at len=4095.
  assign byte_due  = (state == ST_SEND) && udp_txen && (cnt_q < len_q);
  assign fifo_rxen = byte_due && !fifo_empty;
  assign cnt_inc   = cnt_q + LEN_W'(1);

  // Timeout fires on the cycle that would bring the counter up to TIMEOUT_CYC.
  assign tmo_hit = ({1'b0, tmo_q} + 33'd1) >= {1'b0, TIMEOUT_CYC};
  assign tmo_inc = (tmo_q == {TMO_W{1'b1}}) ? tmo_q : tmo_q + TMO_W'(1);

  // Byte lane follows the read issued one cycle earlier; otherwise pad (underflow or past len).
  assign udp_txd = d_sel ? fifo_rxd : PAD_BYTE;

  // Job sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      fd              <= 1'b0;
      err             <= 1'b0;
      flag_udp_tx_req <= 1'b0;
      fs_udp_tx       <= 1'b0;
      udp_tx_len      <= 16'h0000;
      len_q           <= '0;
      cnt_q           <= '0;
      tmo_q           <= '0;
      d_sel           <= 1'b0;
    end else begin
      d_sel <= fifo_rxen;

      case (state)
        ST_IDLE: begin
          if (fs) begin
            len_q      <= dat_tx_len;
            udp_tx_len <= {4'h0, dat_tx_len};
            err        <= 1'b0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            if (dat_tx_len == '0) begin
              // Empty job: no mac transaction at all.
              state <= ST_DONE;
              fd    <= 1'b1;
            end else begin
              state           <= ST_REQ;
              flag_udp_tx_req <= 1'b1;
            end
          end
        end

        ST_REQ: begin
          if (flag_udp_tx_prep) begin
            state           <= ST_SEND;
            flag_udp_tx_req <= 1'b0;
            fs_udp_tx       <= 1'b1;
            tmo_q           <= '0;
          end else if (tmo_hit) begin
            state           <= ST_DONE;
            flag_udp_tx_req <= 1'b0;
            fd              <= 1'b1;
            err             <= 1'b1;
            tmo_q           <= '0;
          end else begin
            tmo_q <= tmo_inc;
          end
        end

        ST_SEND: begin
          // Every owed strobe is counted, read or not; an empty fifo makes it an underflow.
          if (byte_due) begin
            cnt_q <= cnt_inc;
            if (fifo_empty) begin
              err <= 1'b1;
            end
          end
          if (fd_udp_tx) begin
            // Mac may finish early; unread bytes stay in the fifo.
            state     <= ST_DONE;
            fs_udp_tx <= 1'b0;
            fd        <= 1'b1;
            tmo_q     <= '0;
          end else if (byte_due && (cnt_inc == len_q)) begin
            state <= ST_WAIT_FD;
            tmo_q <= '0;
          end
        end

        ST_WAIT_FD: begin
          if (fd_udp_tx) begin
            state     <= ST_DONE;
            fs_udp_tx <= 1'b0;
            fd        <= 1'b1;
            tmo_q     <= '0;
          end else if (tmo_hit) begin
            state     <= ST_DONE;
            fs_udp_tx <= 1'b0;
            fd        <= 1'b1;
            err       <= 1'b1;
            tmo_q     <= '0;
          end else begin
            tmo_q <= tmo_inc;
          end
        end

        ST_DONE: begin
          // Hold done until the requester releases fs.
          if (!fs) begin
            state      <= ST_IDLE;
            fd         <= 1'b0;
            udp_tx_len <= 16'h0000;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_ctrl.sv
// Testbench for udp_tx_ctrl: behavioural fifo and mac models, directed and random jobs.
module tb_udp_tx_ctrl;

  localparam logic [31:0] TMO = 32'd16;
  localparam logic [7:0]  PAD = 8'h00;
  localparam int          MEM = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fs = 1'b0;
  logic        fd;
  logic [11:0] dat_tx_len = 12'd0;
  logic        err;
  logic        fifo_rxen;
  logic [7:0]  fifo_rxd = 8'h00;
  logic        fifo_empty;
  logic        req;
  logic        prep = 1'b0;
  logic [15:0] udp_tx_len;
  logic        fs_udp_tx;
  logic        fd_udp_tx = 1'b0;
  logic        udp_txen = 1'b0;
  logic [7:0]  udp_txd;

  logic [7:0]  fifo_mem [MEM];
  int          rd_ptr = 0;
  int          wr_ptr = 0;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          pend = 1'b0;
  logic [7:0]  pend_exp = 8'h00;
  logic [7:0]  job_q [$];

  udp_tx_ctrl #(.TIMEOUT_CYC(TMO), .PAD_BYTE(PAD)) dut (
    .clk              (clk),
    .rst              (rst),
    .fs               (fs),
    .fd               (fd),
    .dat_tx_len       (dat_tx_len),
    .err              (err),
    .fifo_rxen        (fifo_rxen),
    .fifo_rxd         (fifo_rxd),
    .fifo_empty       (fifo_empty),
    .flag_udp_tx_req  (req),
    .flag_udp_tx_prep (prep),
    .udp_tx_len       (udp_tx_len),
    .fs_udp_tx        (fs_udp_tx),
    .fd_udp_tx        (fd_udp_tx),
    .udp_txen         (udp_txen),
    .udp_txd          (udp_txd)
  );

  always #5 clk = ~clk;

  // Non-FWFT fifo model: data appears the cycle after a read enable.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rxen) begin
      fifo_rxd <= fifo_mem[rd_ptr % MEM];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and check any byte owed from the previous strobe.
  task automatic tick();
    @(negedge clk);
    if (pend) begin
      chk("udp_txd", 32'(udp_txd), 32'(pend_exp));
      pend = 1'b0;
    end
  endtask

  task automatic load_fifo();
    foreach (job_q[i]) begin
      fifo_mem[wr_ptr % MEM] = job_q[i];
      wr_ptr++;
    end
  endtask

  // Start a job and bring it to the data phase.
  task automatic start_job(input int len, input int prep_dly);
    dat_tx_len = 12'(len);
    fs = 1'b1;
    for (int k = 0; k < 4 && !req; k++) tick();
    chk("req_up", 32'(req), 32'd1);
    chk("udp_tx_len", 32'(udp_tx_len), 32'(len));
    repeat (prep_dly) tick();
    chk("req_held", 32'(req), 32'd1);
    prep = 1'b1;
    for (int k = 0; k < 4 && !fs_udp_tx; k++) tick();
    chk("fs_udp_tx_up", 32'(fs_udp_tx), 32'd1);
    chk("req_drop", 32'(req), 32'd0);
    prep = 1'b0;
  endtask

  // Mac strobes: byte i is fifo data while i < len and i < avail, else pad.
  task automatic send_bytes(input int len, input int ntx, input int gap_max);
    int avail;
    int g;
    avail = job_q.size();
    for (int i = 0; i < ntx; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        udp_txen = 1'b0;
        tick();
      end
      pend_exp = (i < len && i < avail) ? job_q[i] : PAD;
      pend = 1'b1;
      udp_txen = 1'b1;
      tick();
    end
    udp_txen = 1'b0;
  endtask

  task automatic run_job(input int len, input int ntx, input int prep_dly, input int gap_max);
    int avail;
    int base;
    int owed;
    int exp_rd;
    avail = job_q.size();
    load_fifo();
    base = rd_ptr;
    start_job(len, prep_dly);
    send_bytes(len, ntx, gap_max);
    owed   = (ntx < len) ? ntx : len;
    exp_rd = (owed < avail) ? owed : avail;
    fd_udp_tx = 1'b1;
    for (int k = 0; k < 8 && !fd; k++) tick();
    chk("fd_up", 32'(fd), 32'd1);
    chk("err", 32'(err), (owed > avail) ? 32'd1 : 32'd0);
    chk("reads", 32'(rd_ptr - base), 32'(exp_rd));
    chk("fs_udp_tx_drop", 32'(fs_udp_tx), 32'd0);
    fd_udp_tx = 1'b0;
    fs = 1'b0;
    tick();
    chk("fd_drop", 32'(fd), 32'd0);
    wr_ptr = rd_ptr;
    job_q.delete();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_fd"},         32'(fd),         32'd0);
    chk({pfx, "_err"},        32'(err),        32'd0);
    chk({pfx, "_req"},        32'(req),        32'd0);
    chk({pfx, "_fs_udp_tx"},  32'(fs_udp_tx),  32'd0);
    chk({pfx, "_fifo_rxen"},  32'(fifo_rxen),  32'd0);
    chk({pfx, "_udp_tx_len"}, 32'(udp_tx_len), 32'd0);
    chk({pfx, "_udp_txd"},    32'(udp_txd),    32'(PAD));
  endtask

  initial begin
    int len;
    int avail;
    int cnt;
    bit saw;
    int base;

    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Four bytes streamed back to back, late prep.
    job_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_job(4, 4, 3, 0);
    // Underflow on the third byte.
    job_q = '{8'h11, 8'h22};
    run_job(3, 3, 1, 0);
    // Mac over-requests: extra strobes get pad, no reads, no err.
    job_q = '{8'h5A, 8'h6B};
    run_job(2, 4, 0, 0);
    // Mac finishes early; remaining bytes stay in the fifo.
    job_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_job(5, 2, 2, 1);

    // Prep never arrives: timeout after TMO request cycles.
    fs = 1'b1;
    dat_tx_len = 12'd3;
    cnt = 0;
    saw = 1'b0;
    for (int k = 0; k < 40 && !fd; k++) begin
      tick();
      if (req) cnt++;
      if (fs_udp_tx) saw = 1'b1;
    end
    chk("tmo_req_cycles", 32'(cnt), TMO);
    chk("tmo_fd", 32'(fd), 32'd1);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_no_fs_udp_tx", 32'(saw), 32'd0);
    fs = 1'b0;
    tick();
    chk("tmo_fd_drop", 32'(fd), 32'd0);

    // Zero-length job: done without touching the mac, err cleared.
    fs = 1'b1;
    dat_tx_len = 12'd0;
    saw = 1'b0;
    for (int k = 0; k < 2 && !fd; k++) begin
      tick();
      if (req) saw = 1'b1;
    end
    chk("len0_fd", 32'(fd), 32'd1);
    chk("len0_err", 32'(err), 32'd0);
    chk("len0_no_req", 32'(saw), 32'd0);
    fs = 1'b0;
    tick();
    chk("len0_fd_drop", 32'(fd), 32'd0);

    // Random jobs with occasional underflow and mac over-requests.
    for (int j = 0; j < 12; j++) begin
      len = int'($urandom_range(1, 40));
      avail = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : len;
      for (int i = 0; i < avail; i++) job_q.push_back(8'($urandom));
      run_job(len, len + int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 2)));
    end

    // Largest length: counter must not wrap.
    for (int i = 0; i < 4095; i++) job_q.push_back(8'($urandom));
    run_job(4095, 4097, 0, 0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 6; i++) job_q.push_back(8'($urandom));
    load_fifo();
    base = rd_ptr;
    start_job(6, 1);
    send_bytes(6, 3, 0);
    chk("mid_reads", 32'(rd_ptr - base), 32'd3);
    rst = 1'b1;
    fs = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    wr_ptr = rd_ptr;
    job_q.delete();
    tick();
    chk("post_rst_req", 32'(req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
